// File: rtl/ld_imm_wr_sched.sv
// ld_imm_wr_sched
//   Two-requester scheduler for load-immediate results. A round-robin
//   arbiter picks one requester per cycle. The winner's operand is either
//   the sign-extended 32-bit immediate {psrc1, psrc0, imm[19:12], 12'h000}
//   (srcType0 == 2'b01) or its 64-bit register data. The result is held in
//   a single stage register that drives the data-array write port.
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   enq_valid/enq_ready    per-requester handshake (at most one ready bit)
//   enq_srcType0, enq_imm, enq_psrc0, enq_psrc1, enq_data, enq_addr
//                          per-requester payload
//   flush                  kills the staged entry and blocks accepts
//   wb_busy                write port is taken this cycle, so the stage stalls
//   wr_valid/wr_addr/wr_data  data-array write request
//
// Optional feature (macro LD_IMM_SCHED_PERF_EN)
//   perf_grants            saturating count of accepted transfers
//   perf_stalls            saturating count of cycles with wr_valid && wb_busy
module ld_imm_wr_sched #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             enq_valid,
  output logic [1:0]             enq_ready,
  input  logic [1:0][1:0]        enq_srcType0,
  input  logic [1:0][19:0]       enq_imm,
  input  logic [1:0][5:0]        enq_psrc0,
  input  logic [1:0][5:0]        enq_psrc1,
  input  logic [1:0][63:0]       enq_data,
  input  logic [1:0][ADDR_W-1:0] enq_addr,
  input  logic                   flush,
  input  logic                   wb_busy,
  output logic                   wr_valid,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [63:0]            wr_data
`ifdef LD_IMM_SCHED_PERF_EN
  ,
  output logic [15:0]            perf_grants,
  output logic [15:0]            perf_stalls
`endif
);

  logic              ptr;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [63:0]       s1_data;

  logic [1:0]  grant;
  logic        wr_fire;
  logic        can_accept;
  logic        accept;
  logic        sel;
  logic [31:0] imm32;
  logic [63:0] operand;

  // ptr names the port preferred when both request.
  always_comb begin
    grant = 2'b00;
    unique case (enq_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign wr_fire = s1_valid & ~wb_busy;
  // Reset also blocks accepts so enq_ready reads 0 while reset is held.
  assign can_accept = ~reset & ~flush & (~s1_valid | wr_fire);
  assign enq_ready  = grant & {2{can_accept}};
  assign accept     = |enq_ready;
  assign sel        = enq_ready[1];

  always_comb begin
    imm32   = {enq_psrc1[sel], enq_psrc0[sel], enq_imm[sel][19:12], 12'h000};
    operand = enq_data[sel];
    if (enq_srcType0[sel] == 2'b01) begin
      operand = {{32{imm32[31]}}, imm32};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= 1'b0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      // flush forces accept low, so the pointer cannot move during a flush.
      if (accept) begin
        ptr <= ~sel;
      end
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
        s1_addr  <= enq_addr[sel];
        s1_data  <= operand;
      end else if (wr_fire) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign wr_valid = s1_valid;
  assign wr_addr  = s1_addr;
  assign wr_data  = s1_data;

`ifdef LD_IMM_SCHED_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept && (perf_grants != 16'hFFFF)) begin
        perf_grants <= perf_grants + 16'd1;
      end
      if (s1_valid && wb_busy && (perf_stalls != 16'hFFFF)) begin
        perf_stalls <= perf_stalls + 16'd1;
      end
    end
  end
`endif

endmodule
